truth_table_sweeper: RTL and testbench



---
 rtl/tt_pkg.sv | 22 ++
 rtl/truth_table_sweeper.sv | 145 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// ----------------------------------------------------------------------------
// tt_pkg
//   Shared definitions for the truth-table sweeper.
//   - FSM state encoding (IDLE, SETTLE, SAMPLE, DONE) as plain 2-bit constants
//   - settle_cnt_w(): width of the settle-interval down-counter
// ----------------------------------------------------------------------------
package tt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_SETTLE = 2'd1;
  localparam state_t S_SAMPLE = 2'd2;
  localparam state_t S_DONE   = 2'd3;

  // The settle counter is loaded with SETTLE-1, so clog2(SETTLE)+1 bits is
  // always enough. The +1 also keeps the width at 1 or more when SETTLE == 1.
  function automatic int settle_cnt_w(input int settle);
    return $clog2(settle) + 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
//   Clocked stimulus initiator for exhaustive combinational gate checks.
//   It drives every input vector 0 .. 2^N_IN-1 in ascending order onto a
//   device under test and onto its golden control model. It waits SETTLE
//   cycles, then compares the two responses. It counts mismatching vectors
//   and records the first failing vector.
//
// Parameters
//   N_IN    number of DUT inputs (stim MSB = first DUT input)
//   SETTLE  cycles between driving a vector and sampling it (>= 1)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   start       begin a sweep; only honoured in IDLE or DONE
//   stim        vector driven to DUT and control model
//   dut_s       DUT response
//   ctl_s       control-model response
//   busy        sweep in progress (SETTLE or SAMPLE)
//   done        sweep finished; results valid
//   pass        done with zero mismatches
//   err_count   number of mismatching vectors (saturates naturally at 2^N_IN)
//   fail_valid  a mismatch has been recorded during this sweep
//   fail_vec    first mismatching vector (meaningful when fail_valid = 1)
//
// Build options
//   TT_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep
//                       immediately and stim keeps showing the failing vector.
// ----------------------------------------------------------------------------
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_s,
  input  logic            ctl_s,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int                 CNT_W       = settle_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE - 1);
  // The vector counter is one bit wider than stim. This keeps the terminal
  // compare free of wrap-around.
  localparam logic [N_IN:0]      LAST_VEC    = {1'b0, {N_IN{1'b1}}};

  state_t           state;
  logic [N_IN:0]    vec;
  logic [CNT_W-1:0] settle_cnt;
  logic             mismatch;
  logic             last_vec;

  // In simulation, X/Z on either response must count as a failure, so a
  // case-inequality compare is used there. In hardware the two are the same.
`ifdef SYNTHESIS
  assign mismatch = dut_s ^ ctl_s;
`else
  assign mismatch = (dut_s !== ctl_s);
`endif

  assign last_vec = (vec == LAST_VEC);

  assign stim = vec[N_IN-1:0];
  assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
  assign done = (state == S_DONE);
  assign pass = (state == S_DONE) && (err_count == '0);

  // NOTE: every register here is assigned with <= so that all updates take
  // effect together at the clock edge. Blocking '=' would let later
  // statements see values from the same edge and would create races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        // A restart from DONE behaves exactly like a start from IDLE.
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            vec        <= '0;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        S_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              fail_vec   <= vec[N_IN-1:0];
              fail_valid <= 1'b1;
            end
          end
`ifdef TT_STOP_ON_FAIL_EN
          // vec is left untouched on the way to DONE, so stim keeps showing
          // the failing vector for waveform debug.
          if (mismatch || last_vec) begin
            state <= S_DONE;
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
`else
          if (last_vec) begin
            state <= S_DONE;
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// tb_truth_table_sweeper
//   Two sweeper instances: inst 0 uses SETTLE=1 and inst 1 uses SETTLE=3.
//   Each one drives a behavioural gate pair selected per run:
//     IMPL  - implication built from NANDs  ~(~a & b)  (matches control)
//     AND   - a & b                          (mismatches on 00 and 10)
//     COPY  - copy of the control model      (matches control)
//   The control model is a | ~b, with a = stim[1] and b = stim[0].
//   Each accepted start pushes its expected final result onto a per-instance
//   queue. A monitor watches for done rising, pops the queue and compares.
//   The monitor also checks stim ordering and the per-vector hold time.
// ----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  localparam int SEL_IMPL = 0;
  localparam int SEL_AND  = 1;
  localparam int SEL_COPY = 2;
  localparam int ST [2] = '{1, 3};

  typedef struct {
    int err;
    int fv;
    int fvec;
    int pass;
    int cycles;
    int nvec;
    int stim;
    int t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [2];
  logic [1:0] stim_w  [2];
  logic       dut_w   [2];
  logic       ctl_w   [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic [2:0] err_w   [2];
  logic       fv_w    [2];
  logic [1:0] fvec_w  [2];
  int         sel_v   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q0 [$];
  exp_t q1 [$];

  logic       busy_q [2];
  logic       done_q [2];
  logic [1:0] cur    [2];
  int         run    [2];
  int         nvec   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- gate models ----------------
  function automatic logic model_ctl(input logic [1:0] v);
    return v[1] | ~v[0];
  endfunction

  function automatic logic model_dut(input int sel, input logic [1:0] v);
    logic na;
    na = ~(v[1] & v[1]);
    case (sel)
      SEL_IMPL: return ~(na & v[0]);
      SEL_AND:  return v[1] & v[0];
      default:  return model_ctl(v);
    endcase
  endfunction

  assign ctl_w[0] = model_ctl(stim_w[0]);
  assign ctl_w[1] = model_ctl(stim_w[1]);
  assign dut_w[0] = model_dut(sel_v[0], stim_w[0]);
  assign dut_w[1] = model_dut(sel_v[1], stim_w[1]);

  // ---------------- DUTs ----------------
  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .stim(stim_w[0]),
    .dut_s(dut_w[0]), .ctl_s(ctl_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err_w[0]), .fail_valid(fv_w[0]),
    .fail_vec(fvec_w[0])
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .stim(stim_w[1]),
    .dut_s(dut_w[1]), .ctl_s(ctl_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err_w[1]), .fail_valid(fv_w[1]),
    .fail_vec(fvec_w[1])
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int err, input int fv, input int fvec,
                              input int pass, input int cycles, input int nv,
                              input int stim);
    exp_t e;
    e.err = err; e.fv = fv; e.fvec = fvec; e.pass = pass;
    e.cycles = cycles; e.nvec = nv; e.stim = stim; e.t0 = 0;
    return e;
  endfunction

  task automatic check_reset(input int i);
    check($sformatf("rst%0d.stim", i), 32'(stim_w[i]), 0);
    check($sformatf("rst%0d.busy", i), 32'(busy_w[i]), 0);
    check($sformatf("rst%0d.done", i), 32'(done_w[i]), 0);
    check($sformatf("rst%0d.pass", i), 32'(pass_w[i]), 0);
    check($sformatf("rst%0d.err", i), 32'(err_w[i]), 0);
    check($sformatf("rst%0d.fv", i), 32'(fv_w[i]), 0);
    check($sformatf("rst%0d.fvec", i), 32'(fvec_w[i]), 0);
  endtask

  // Pulse start for one cycle. If push is set, the run is expected to
  // complete and its expected result goes to the scoreboard.
  task automatic run_sweep(input int i, input int sel, input exp_t e,
                           input bit push);
    @(negedge clk);
    sel_v[i]   = sel;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    e.t0 = cyc;
    if (push) begin
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic wait_drain(input int i);
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    for (int k = 0; k < 300 && sz > 0; k++) begin
      @(negedge clk);
      sz = (i == 0) ? q0.size() : q1.size();
    end
    check($sformatf("drain%0d.pending", i), 32'(sz), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy_w[i] && !busy_q[i]) begin
        cur[i]  = stim_w[i];
        run[i]  = 1;
        nvec[i] = 1;
        check($sformatf("mon%0d.first_vec", i), 32'(stim_w[i]), 0);
      end else if (busy_w[i]) begin
        if (stim_w[i] == cur[i]) begin
          run[i]++;
        end else begin
          check($sformatf("mon%0d.hold", i), 32'(run[i]), 32'(ST[i] + 1));
          check($sformatf("mon%0d.order", i), 32'(stim_w[i]),
                32'(2'(cur[i] + 2'd1)));
          cur[i] = stim_w[i];
          run[i] = 1;
          nvec[i]++;
        end
      end

      if (done_w[i] && !done_q[i]) begin
        exp_t e;
        int   sz;
        sz = (i == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          check($sformatf("mon%0d.unexpected_done", i), 32'(sz), 1);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("mon%0d.last_hold", i), 32'(run[i]), 32'(ST[i] + 1));
          check($sformatf("mon%0d.nvec", i), 32'(nvec[i]), 32'(e.nvec));
          check($sformatf("mon%0d.cycles", i), 32'(cyc - e.t0), 32'(e.cycles));
          check($sformatf("mon%0d.err", i), 32'(err_w[i]), 32'(e.err));
          check($sformatf("mon%0d.fv", i), 32'(fv_w[i]), 32'(e.fv));
          check($sformatf("mon%0d.fvec", i), 32'(fvec_w[i]), 32'(e.fvec));
          check($sformatf("mon%0d.pass", i), 32'(pass_w[i]), 32'(e.pass));
          check($sformatf("mon%0d.stim", i), 32'(stim_w[i]), 32'(e.stim));
          check($sformatf("mon%0d.busy", i), 32'(busy_w[i]), 0);
        end
      end
      busy_q[i] = busy_w[i];
      done_q[i] = done_w[i];
    end
  end

  // ---------------- stimulus ----------------
  exp_t e_impl, e_and, e_copy3;
  logic [1:0] abort_vec;

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      sel_v[i]   = SEL_IMPL;
      busy_q[i]  = 1'b0;
      done_q[i]  = 1'b0;
      cur[i]     = '0;
      run[i]     = 0;
      nvec[i]    = 0;
    end

    e_impl  = mk(0, 0, 0, 1, 8, 4, 3);
    e_copy3 = mk(0, 0, 0, 1, 16, 4, 3);
`ifdef TT_STOP_ON_FAIL_EN
    e_and     = mk(1, 1, 0, 0, 2, 1, 0);
    abort_vec = 2'b00;
`else
    e_and     = mk(2, 1, 0, 0, 8, 4, 3);
    abort_vec = 2'b10;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    @(negedge clk);
    check_reset(0);

    // Clean sweep with the NAND implication, SETTLE=1
    run_sweep(0, SEL_IMPL, e_impl, 1'b1);
    wait_drain(0);

    // Restart from DONE with the AND gate: done drops on the start edge
    run_sweep(0, SEL_AND, e_and, 1'b1);
    check("restart.done_low", 32'(done_w[0]), 0);
    check("restart.busy_high", 32'(busy_w[0]), 1);
    check("restart.err_cleared", 32'(err_w[0]), 0);
    wait_drain(0);

    // Results hold in DONE
    repeat (5) @(negedge clk);
    check("hold.done", 32'(done_w[0]), 1);
    check("hold.err", 32'(err_w[0]), 32'(e_and.err));

    // SETTLE=3, control copy: 16-cycle sweep, 4 cycles per vector
    run_sweep(1, SEL_COPY, e_copy3, 1'b1);
    wait_drain(1);

    // Asynchronous reset during SETTLE of a vector mid-sweep
    run_sweep(0, SEL_AND, e_and, 1'b0);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        if (busy_w[0] && stim_w[0] == abort_vec) break;
        @(negedge clk);
      end
      check("abort.reached_vec", 32'(k < 50), 1);
    end
    rst = 1'b1;
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, SEL_AND, e_and, 1'b1);
    wait_drain(0);

    // start while busy is ignored; start in DONE clears results and reruns
    run_sweep(0, SEL_AND, e_and, 1'b1);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_drain(0);
    run_sweep(0, SEL_IMPL, e_impl, 1'b1);
    check("rerun.fv_cleared", 32'(fv_w[0]), 0);
    wait_drain(0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
